// File: rtl/set_pkg.sv
// Shared definitions for the SET host sequencer: host FSM state codes,
// SET mode codes, field widths and the job-word width helper.
package set_pkg;

   // Job and result field widths
   localparam int CENTRAL_W  = 24;
   localparam int RADIUS_W   = 12;
   localparam int MODE_W     = 2;
   localparam int COUNT_W    = 8;

   // Job word without the tag: {mode, radius, central}
   localparam int JOB_BASE_W = CENTRAL_W + RADIUS_W + MODE_W;

   // Host FSM state codes
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   // SET mode codes
   localparam logic [1:0] MODE_A   = 2'b00;  // inside A
   localparam logic [1:0] MODE_AND = 2'b01;  // inside A and B
   localparam logic [1:0] MODE_XOR = 2'b10;  // inside exactly one of A, B
   localparam logic [1:0] MODE_TWO = 2'b11;  // inside exactly two of A, B, C

   // Full FIFO word width for a given tag width
   function automatic int job_w(input int tag_w);
      return JOB_BASE_W + tag_w;
   endfunction

endpackage

// File: rtl/set_job_fifo.sv
// Job queue for the SET host sequencer.
// Circular buffer with log2(DEPTH)+1 bit pointers that wrap modulo 2*DEPTH:
// equal pointers mean empty, equal low bits with differing MSBs mean full.
// The head word is presented on dout whenever the FIFO is non-empty.
module set_job_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 42
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   // Reject depths the pointer arithmetic cannot represent
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("set_job_fifo: DEPTH must be a power of 2 and >= 2");
   end

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   // Qualify the requests so the pointers can never overrun
   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
   end

   // Pointer registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   // Storage array; contents are only meaningful between push and pop
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   // Status flags and head-of-queue read
   always_comb begin
      empty = (wr_ptr == rd_ptr);
      full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      dout  = mem[rd_ptr[AW-1:0]];
   end

endmodule

// File: rtl/set_host_seq.sv
// Host-side initiator for the SET candidate-count engine.
// Buffers jobs in set_job_fifo, issues each one to the engine with a single
// eng_en pulse, captures eng_candidate on eng_valid and returns the tagged
// result on a valid/ready stream. Only one job is ever outstanding: the next
// issue waits until the previous result has been accepted.
//
// Optional feature macro: SET_HOST_TIMEOUT_EN
//   defined   - a watchdog counts RUN cycles; after TIMEOUT_CYC cycles without
//               eng_valid the job completes with res_err=1 and res_count=0.
//   undefined - RUN waits for eng_valid indefinitely and res_err is tied 0.
//
// Handshake semantics (both streams): a transfer happens on a rising clk edge
// where valid && ready are both 1. A producer that raises valid keeps it and
// its data stable until that transfer; ready never depends on valid.
module set_host_seq
   import set_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int TAG_W       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   // job stream
   input  logic                 job_valid,
   output logic                 job_ready,
   input  logic [CENTRAL_W-1:0] job_central,
   input  logic [RADIUS_W-1:0]  job_radius,
   input  logic [MODE_W-1:0]    job_mode,
   input  logic [TAG_W-1:0]     job_tag,
   // engine interface
   output logic                 eng_en,
   output logic [CENTRAL_W-1:0] eng_central,
   output logic [RADIUS_W-1:0]  eng_radius,
   output logic [MODE_W-1:0]    eng_mode,
   input  logic                 eng_busy,
   input  logic                 eng_valid,
   input  logic [COUNT_W-1:0]   eng_candidate,
   // result stream
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [COUNT_W-1:0]   res_count,
   output logic [TAG_W-1:0]     res_tag,
   output logic                 res_err,
   // status
   output logic                 host_idle,
   output logic [1:0]           host_state
);

   localparam int JOB_W = job_w(TAG_W);

   // The watchdog limit must allow at least one RUN cycle
   if (TIMEOUT_CYC < 1) begin : g_timeout_check
      $error("set_host_seq: TIMEOUT_CYC must be >= 1");
   end

   logic [1:0]       state;
   logic [1:0]       next_state;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [JOB_W-1:0] fifo_din;
   logic [JOB_W-1:0] fifo_dout;
   logic [TAG_W-1:0] cur_tag;
   logic             timeout_hit;

   // ------------------------------------------------------------------
   // Job queue
   // ------------------------------------------------------------------
   assign fifo_din  = {job_tag, job_mode, job_radius, job_central};
   // No bypass and no pop-through: a full FIFO refuses even on a pop cycle
   assign job_ready = !fifo_full;

   set_job_fifo #(
      .DEPTH (DEPTH),
      .W     (JOB_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (job_valid && job_ready),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // ------------------------------------------------------------------
   // Host FSM
   // ------------------------------------------------------------------

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (pop) next_state = ST_ISSUE;
         ST_ISSUE: next_state = ST_RUN;
         ST_RUN: begin
            if (eng_valid || timeout_hit) next_state = ST_IDLE;
         end
         default:  next_state = ST_IDLE;
      endcase
   end

   // FSM outputs. A pop needs a free result slot (empty, or being accepted
   // this very cycle) and an idle engine, which also guarantees that the
   // following ISSUE cycle never pulses eng_en into a busy engine.
   always_comb begin
      pop        = 1'b0;
      eng_en     = 1'b0;
      host_state = state;
      host_idle  = 1'b0;
      if (state == ST_IDLE && !fifo_empty && (!res_valid || res_ready) && !eng_busy)
         pop = 1'b1;
      if (state == ST_ISSUE)
         eng_en = 1'b1;
      if (state == ST_IDLE && fifo_empty && !res_valid)
         host_idle = 1'b1;
   end

   // ------------------------------------------------------------------
   // Engine data registers: loaded only on the IDLE pop, so they stay
   // stable from eng_en through result capture.
   // ------------------------------------------------------------------

   // Latch the head job for the engine and remember its tag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         eng_central <= '0;
         eng_radius  <= '0;
         eng_mode    <= '0;
         cur_tag     <= '0;
      end else if (pop) begin
         eng_central <= fifo_dout[CENTRAL_W-1:0];
         eng_radius  <= fifo_dout[CENTRAL_W +: RADIUS_W];
         eng_mode    <= fifo_dout[CENTRAL_W+RADIUS_W +: MODE_W];
         cur_tag     <= fifo_dout[JOB_BASE_W +: TAG_W];
      end
   end

   // ------------------------------------------------------------------
   // Watchdog (optional)
   // ------------------------------------------------------------------
`ifdef SET_HOST_TIMEOUT_EN
   localparam int WD_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [WD_W-1:0] wdog;

   // Count RUN cycles; cleared while the job is being issued
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  wdog <= '0;
      else if (state == ST_ISSUE) wdog <= '0;
      else if (state == ST_RUN)   wdog <= wdog + WD_W'(1);
   end

   // Expiry on the TIMEOUT_CYC-th RUN cycle; a real result that cycle wins
   assign timeout_hit = (state == ST_RUN) && !eng_valid &&
                        (wdog == WD_W'(TIMEOUT_CYC - 1));

   // Error flag travels with the result it belongs to
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              res_err <= 1'b0;
      else if (state == ST_RUN && eng_valid) res_err <= 1'b0;
      else if (timeout_hit)                  res_err <= 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
   assign res_err     = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Result register. eng_valid outside RUN is ignored, which also covers
   // a late strobe after a watchdog expiry.
   // ------------------------------------------------------------------

   // Capture the engine result (or the timeout marker) and hold until accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid <= 1'b0;
         res_count <= '0;
         res_tag   <= '0;
      end else if (state == ST_RUN && eng_valid) begin
         res_valid <= 1'b1;
         res_count <= eng_candidate;
         res_tag   <= cur_tag;
      end else if (timeout_hit) begin
         res_valid <= 1'b1;
         res_count <= '0;
         res_tag   <= cur_tag;
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_set_host_seq.sv
// Directed bench for set_host_seq with a behavioural SET engine model.
// Build with +define+SET_HOST_TIMEOUT_EN to add the watchdog scenario.
module tb_set_host_seq;
   import set_pkg::*;

   localparam int TAG_W = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic              job_valid = 1'b0;
   logic              job_ready;
   logic [23:0]       job_central = '0;
   logic [11:0]       job_radius = '0;
   logic [1:0]        job_mode = '0;
   logic [TAG_W-1:0]  job_tag = '0;
   logic              eng_en;
   logic [23:0]       eng_central;
   logic [11:0]       eng_radius;
   logic [1:0]        eng_mode;
   logic              eng_busy;
   logic              eng_valid;
   logic [7:0]        eng_candidate;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [7:0]        res_count;
   logic [TAG_W-1:0]  res_tag;
   logic              res_err;
   logic              host_idle;
   logic [1:0]        host_state;

   set_host_seq #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT_CYC(20)) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready), .job_central(job_central),
      .job_radius(job_radius), .job_mode(job_mode), .job_tag(job_tag),
      .eng_en(eng_en), .eng_central(eng_central), .eng_radius(eng_radius), .eng_mode(eng_mode),
      .eng_busy(eng_busy), .eng_valid(eng_valid), .eng_candidate(eng_candidate),
      .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count), .res_tag(res_tag),
      .res_err(res_err), .host_idle(host_idle), .host_state(host_state)
   );

   int checks = 0;
   int passes = 0;

   // ---------------- engine model ----------------
   // Lattice points (x,y in 0..15) inside circle k: dx^2+dy^2 <= r^2.
   function automatic logic [7:0] set_count(input logic [23:0] c, input logic [11:0] r,
                                            input logic [1:0] m);
      int cnt;
      int cx[3], cy[3], rr[3];
      bit in_c[3];
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
         cx[k] = int'(c[23-8*k -: 4]);
         cy[k] = int'(c[19-8*k -: 4]);
         rr[k] = int'(r[11-4*k -: 4]);
      end
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            for (int k = 0; k < 3; k++)
               in_c[k] = ((x-cx[k])*(x-cx[k]) + (y-cy[k])*(y-cy[k])) <= rr[k]*rr[k];
            case (m)
               MODE_A:   if (in_c[0]) cnt++;
               MODE_AND: if (in_c[0] && in_c[1]) cnt++;
               MODE_XOR: if (in_c[0] != in_c[1]) cnt++;
               default:  if ((int'(in_c[0]) + int'(in_c[1]) + int'(in_c[2])) == 2) cnt++;
            endcase
         end
      end
      return cnt[7:0];
   endfunction

   logic       m_busy;
   logic       m_valid;
   logic [7:0] m_cand;
   int         m_cnt;
   int         m_lat = 2;
   bit         m_mute = 1'b0;     // engine ignores eng_en entirely
   bit         busy_force = 1'b0; // external busy override

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy <= 1'b0; m_valid <= 1'b0; m_cand <= '0; m_cnt <= 0;
      end else begin
         m_valid <= 1'b0;
         if (eng_en && !m_mute) begin
            m_busy <= 1'b1;
            m_cnt  <= m_lat;
         end else if (m_busy) begin
            if (m_cnt == 0) begin
               m_busy  <= 1'b0;
               m_valid <= 1'b1;
               m_cand  <= set_count(eng_central, eng_radius, eng_mode);
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end
   end

   assign eng_busy      = m_busy | busy_force;
   assign eng_valid     = m_valid;
   assign eng_candidate = m_cand;

   // ---------------- monitor / scoreboard capture ----------------
   int   cyc = 0, en_count = 0, en_cyc = 0, val_cyc = 0, en_gap = 0;
   int   push_count = 0, push_cyc = 0, rv_cyc = 0, busy_viol = 0;
   logic rv_q = 1'b0;
   logic [TAG_W+8:0] res_q[$];   // {err, tag, count}

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (eng_en) begin
         en_count <= en_count + 1;
         en_cyc   <= cyc;
         en_gap   <= cyc - val_cyc;
      end
      if (eng_valid) val_cyc <= cyc;
      if (job_valid && job_ready) begin
         push_count <= push_count + 1;
         push_cyc   <= cyc;
      end
      rv_q <= res_valid;
      if (res_valid && !rv_q) rv_cyc <= cyc;
      if (res_valid && res_ready) res_q.push_back({res_err, res_tag, res_count});
      if (eng_en && eng_busy) busy_viol <= busy_viol + 1;
   end

   // ---------------- driver tasks ----------------
   task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                           input logic [TAG_W-1:0] t);
      int n;
      n = 0;
      job_central = c; job_radius = r; job_mode = m; job_tag = t; job_valid = 1'b1;
      while (!job_ready && n < 100) begin @(negedge clk); n++; end
      if (!job_ready) begin
         checks++;
         $display("FAIL push_timeout: job_ready=%0b required 1 (tag %0d)", job_ready, t);
      end
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic wait_results(input int n, input int max_cyc);
      int k;
      k = 0;
      res_ready = 1'b1;
      while (res_q.size() < n && k < max_cyc) begin @(negedge clk); k++; end
      res_ready = 1'b0;
      checks++;
      if (res_q.size() < n) $display("FAIL result_timeout: got %0d results required %0d", res_q.size(), n);
      else passes++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int n, en0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (job_ready !== 1'b1) $display("FAIL rst_job_ready: got %0b required 1", job_ready); else passes++;
      checks++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid: got %0b required 0", res_valid); else passes++;
      checks++; if (eng_en !== 1'b0) $display("FAIL rst_eng_en: got %0b required 0", eng_en); else passes++;
      checks++; if (host_idle !== 1'b1) $display("FAIL rst_host_idle: got %0b required 1", host_idle); else passes++;
      checks++; if ({res_count, res_tag, res_err} !== 13'd0) $display("FAIL rst_res_data: got %0h required 0", {res_count, res_tag, res_err}); else passes++;
      checks++; if ({eng_central, eng_radius, eng_mode} !== 38'd0) $display("FAIL rst_eng_data: got %0h required 0", {eng_central, eng_radius, eng_mode}); else passes++;
      rst = 1'b1;
      @(negedge clk);
      // reset in the middle of a long engine run
      m_lat = 30;
      en0 = en_count;
      push_job(24'h440000, 12'h200, MODE_A, 4'd7);
      n = 0;
      while (en_count == en0 && n < 20) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      checks++; if (host_state !== ST_RUN) $display("FAIL midrun_state: got %0d required %0d", host_state, ST_RUN); else passes++;
      rst = 1'b0;
      #1;
      checks++; if (job_ready !== 1'b1) $display("FAIL midrun_rst_job_ready: got %0b required 1", job_ready); else passes++;
      checks++; if (res_valid !== 1'b0) $display("FAIL midrun_rst_res_valid: got %0b required 0", res_valid); else passes++;
      checks++; if (eng_en !== 1'b0) $display("FAIL midrun_rst_eng_en: got %0b required 0", eng_en); else passes++;
      checks++; if (host_idle !== 1'b1) $display("FAIL midrun_rst_host_idle: got %0b required 1", host_idle); else passes++;
      @(negedge clk);
      rst = 1'b1;
      en0 = en_count;
      res_q.delete();
      repeat (10) @(negedge clk);
      checks++; if (en_count !== en0) $display("FAIL post_rst_no_en: got %0d pulses required 0", en_count - en0); else passes++;
      checks++; if (res_valid !== 1'b0) $display("FAIL post_rst_res_valid: got %0b required 0", res_valid); else passes++;
      m_lat = 2;
   endtask

   task automatic test_single();
      int en0;
      res_q.delete();
      m_lat = 4;
      en0 = en_count;
      push_job(24'h440000, 12'h200, MODE_A, 4'd3);
      wait_results(1, 100);
      checks++; if (en_count - en0 !== 1) $display("FAIL single_en_pulses: got %0d required 1", en_count - en0); else passes++;
      checks++; if (en_cyc - push_cyc !== 2) $display("FAIL single_latency: got %0d required 2", en_cyc - push_cyc); else passes++;
      checks++; if (res_q[0][7:0] !== 8'd13) $display("FAIL single_count: got %0d required 13", res_q[0][7:0]); else passes++;
      checks++; if (res_q[0][11:8] !== 4'd3) $display("FAIL single_tag: got %0d required 3", res_q[0][11:8]); else passes++;
      checks++; if (res_q[0][12] !== 1'b0) $display("FAIL single_err: got %0b required 0", res_q[0][12]); else passes++;
   endtask

   task automatic test_back_pressure();
      logic [7:0] exp_cnt[4] = '{8'd13, 8'd5, 8'd8, 8'd2};
      logic [7:0] c0;
      logic [TAG_W-1:0] t0;
      int n, en0;
      bit stable;
      res_q.delete();
      res_ready = 1'b0;
      m_lat = 3;
      push_job(24'h445400, 12'h210, MODE_A,   4'd0);
      push_job(24'h445400, 12'h210, MODE_AND, 4'd1);
      push_job(24'h445400, 12'h210, MODE_XOR, 4'd2);
      push_job(24'h4454AA, 12'h110, MODE_TWO, 4'd3);
      n = 0;
      while (!res_valid && n < 50) begin @(negedge clk); n++; end
      checks++; if (res_valid !== 1'b1) $display("FAIL bp_first_valid: got %0b required 1", res_valid); else passes++;
      c0 = res_count; t0 = res_tag; en0 = en_count; stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || res_count !== c0 || res_tag !== t0) stable = 1'b0;
      end
      checks++; if (stable !== 1'b1) $display("FAIL bp_stable: got %0b required 1", stable); else passes++;
      checks++; if (en_count !== en0) $display("FAIL bp_no_issue: got %0d pulses required 0", en_count - en0); else passes++;
      wait_results(4, 200);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (res_q[i][11:8] !== 4'(i) || res_q[i][7:0] !== exp_cnt[i] || res_q[i][12] !== 1'b0)
            $display("FAIL bp_result%0d: got tag %0d count %0d err %0b required tag %0d count %0d err 0",
                     i, res_q[i][11:8], res_q[i][7:0], res_q[i][12], i, exp_cnt[i]);
         else passes++;
      end
   endtask

   task automatic test_back_to_back();
      res_q.delete();
      m_lat = 2;
      res_ready = 1'b1;
      push_job(24'h440000, 12'h200, MODE_A, 4'd5);
      push_job(24'h445400, 12'h210, MODE_AND, 4'd6);
      wait_results(2, 100);
      checks++; if (en_gap !== 2) $display("FAIL b2b_gap: got %0d required 2", en_gap); else passes++;
      checks++;
      if (res_q[0][11:8] !== 4'd5 || res_q[1][11:8] !== 4'd6 || res_q[1][7:0] !== 8'd5)
         $display("FAIL b2b_results: got tags %0d,%0d count %0d required 5,6 count 5",
                  res_q[0][11:8], res_q[1][11:8], res_q[1][7:0]);
      else passes++;
   endtask

   task automatic test_fifo_full();
      int pc0, n;
      res_q.delete();
      res_ready = 1'b0;
      busy_force = 1'b1;
      m_lat = 2;
      pc0 = push_count;
      for (int i = 0; i < 4; i++) push_job(24'h440000, 12'h100, MODE_A, 4'(8 + i));
      checks++; if (job_ready !== 1'b0) $display("FAIL full_ready_drop: got %0b required 0", job_ready); else passes++;
      job_central = 24'h440000; job_radius = 12'h100; job_mode = MODE_A; job_tag = 4'd12; job_valid = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (push_count - pc0 !== 4) $display("FAIL full_fifth_held: got %0d accepted required 4", push_count - pc0); else passes++;
      busy_force = 1'b0;
      n = 0;
      while (!job_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      job_valid = 1'b0;
      checks++; if (push_count - pc0 !== 5) $display("FAIL full_fifth_accept: got %0d accepted required 5", push_count - pc0); else passes++;
      wait_results(5, 300);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (res_q[i][11:8] !== 4'(8 + i) || res_q[i][7:0] !== 8'd5)
            $display("FAIL full_order%0d: got tag %0d count %0d required tag %0d count 5",
                     i, res_q[i][11:8], res_q[i][7:0], 8 + i);
         else passes++;
      end
   endtask

   task automatic test_busy_guard();
      int en0;
      res_q.delete();
      busy_force = 1'b1;
      en0 = en_count;
      push_job(24'h440000, 12'h200, MODE_A, 4'd13);
      repeat (8) @(negedge clk);
      checks++; if (en_count !== en0) $display("FAIL busy_no_en: got %0d pulses required 0", en_count - en0); else passes++;
      busy_force = 1'b0;
      wait_results(1, 100);
      checks++; if (en_count - en0 !== 1 || res_q[0][11:8] !== 4'd13)
         $display("FAIL busy_release: got %0d pulses tag %0d required 1 pulse tag 13", en_count - en0, res_q[0][11:8]);
      else passes++;
      checks++; if (busy_viol !== 0) $display("FAIL en_while_busy: got %0d required 0", busy_viol); else passes++;
   endtask

`ifdef SET_HOST_TIMEOUT_EN
   task automatic test_timeout();
      res_q.delete();
      m_mute = 1'b1;
      push_job(24'h440000, 12'h200, MODE_A, 4'd5);
      wait_results(1, 100);
      checks++; if (res_q[0][12] !== 1'b1) $display("FAIL to_err: got %0b required 1", res_q[0][12]); else passes++;
      checks++; if (res_q[0][7:0] !== 8'd0) $display("FAIL to_count: got %0d required 0", res_q[0][7:0]); else passes++;
      checks++; if (res_q[0][11:8] !== 4'd5) $display("FAIL to_tag: got %0d required 5", res_q[0][11:8]); else passes++;
      checks++; if (rv_cyc - en_cyc !== 21) $display("FAIL to_delay: got %0d required 21", rv_cyc - en_cyc); else passes++;
      m_mute = 1'b0;
      res_q.delete();
      push_job(24'h440000, 12'h200, MODE_A, 4'd6);
      wait_results(1, 100);
      checks++; if (res_q[0] !== {1'b0, 4'd6, 8'd13}) $display("FAIL to_recover: got %0h required %0h", res_q[0], {1'b0, 4'd6, 8'd13}); else passes++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_pressure();
      test_back_to_back();
      test_fifo_full();
      test_busy_guard();
`ifdef SET_HOST_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
